pcie_rx_avst_ingress_buf: RTL and testbench

//  Parametrised RX AVST ingress buffer between PCIe HIP RX and pcie_checker. Generalises the fixed
//  2-ch/256-deep RX FIFO: configurable channel count, depth and HIP ready latency. Adds

---
 rtl/pcie_rx_avst_ingress_buf.sv | 98 +++++++++
 tb/tb_pcie_rx_avst_ingress_buf.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pcie_rx_avst_ingress_buf.sv
// pcie_rx_avst_ingress_buf: show-ahead RX AVST ingress FIFO with latency-aware ready, drop-on-overflow and fill watermark
// Ports: i_clk/i_sclr clock and sync reset; i_in_valid/i_in_data HIP beat in, o_in_ready registered ready;
// o_out_valid/o_out_ch_valid/o_out_data head beat, i_out_rdack pop; o_used/o_hwm fill and peak fill;
// i_err_clr clears o_ovf_sticky/o_ovf_cnt/o_hwm.
module pcie_rx_avst_ingress_buf #(
  parameter int NUM_CH        = 2,
  parameter int CH_DATA_W     = 280,
  parameter int DEPTH_LOG2    = 8,
  parameter int READY_LATENCY = 20,
  parameter int OVF_CNT_W     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_sclr,
  input  logic [NUM_CH-1:0]           i_in_valid,
  input  logic [NUM_CH*CH_DATA_W-1:0] i_in_data,
  output logic                        o_in_ready,
  output logic                        o_out_valid,
  output logic [NUM_CH-1:0]           o_out_ch_valid,
  output logic [NUM_CH*CH_DATA_W-1:0] o_out_data,
  input  logic                        i_out_rdack,
  output logic [DEPTH_LOG2:0]         o_used,
  output logic [DEPTH_LOG2:0]         o_hwm,
  input  logic                        i_err_clr,
  output logic                        o_ovf_sticky,
  output logic [OVF_CNT_W-1:0]        o_ovf_cnt
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int DW = NUM_CH*CH_DATA_W;
  localparam int BW = DW+NUM_CH;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] RDY_TH = (DEPTH_LOG2+1)'(DEPTH-READY_LATENCY);
  generate
    if (NUM_CH < 1 || READY_LATENCY >= DEPTH-1) begin : g_bad_cfg
      $error("pcie_rx_avst_ingress_buf: NUM_CH must be >=1 and READY_LATENCY < DEPTH-1");
    end
  endgenerate
  logic [BW-1:0]           r_mem [DEPTH];
  logic [BW-1:0]           r_head;
  logic [DEPTH_LOG2-1:0]   r_wr, r_rd;
  logic [DEPTH_LOG2:0]     r_used, r_hwm;
  logic                    r_in_ready, r_ovf_sticky;
  logic [OVF_CNT_W-1:0]    r_ovf_cnt;
  logic [BW-1:0]           w_beat;
  logic                    w_any, w_out_valid, w_pop, w_full, w_push, w_drop;
  logic                    w_load, w_from_ram, w_bypass, w_ram_wr;
  logic [DEPTH_LOG2:0]     w_used_next, w_hwm_base;
  logic [OVF_CNT_W-1:0]    w_cnt_base;
  // The head beat lives in r_head; the RAM holds only the beats behind it.
  // A beat entering with no older beat in the RAM bypasses straight into r_head.
  always_comb begin
    w_beat      = {i_in_valid, i_in_data};
    w_any       = |i_in_valid;
    w_out_valid = r_used != '0;
    w_pop       = i_out_rdack & w_out_valid;
    w_full      = r_used == FULL;
    w_push      = w_any & (~w_full | w_pop);
    w_drop      = w_any & w_full & ~w_pop;
    w_load      = ~w_out_valid | w_pop;
    w_from_ram  = w_load & (r_used > 1);
    w_bypass    = w_load & (r_used <= 1) & w_push;
    w_ram_wr    = w_push & ~w_bypass;
    w_used_next = r_used + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
    w_hwm_base  = i_err_clr ? '0 : r_hwm;
    w_cnt_base  = i_err_clr ? '0 : r_ovf_cnt;
  end
  always_ff @(posedge i_clk) begin
    if (w_ram_wr) r_mem[r_wr] <= w_beat;
    if (w_from_ram) r_head <= r_mem[r_rd];
    else if (w_bypass) r_head <= w_beat;
  end
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_used       <= '0;
      r_in_ready   <= 1'b0;
      r_hwm        <= '0;
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      r_wr         <= r_wr + DEPTH_LOG2'(w_ram_wr);
      r_rd         <= r_rd + DEPTH_LOG2'(w_from_ram);
      r_used       <= w_used_next;
      r_in_ready   <= w_used_next < RDY_TH;
      r_hwm        <= w_used_next > w_hwm_base ? w_used_next : w_hwm_base;
      r_ovf_sticky <= w_drop | (~i_err_clr & r_ovf_sticky);
      r_ovf_cnt    <= w_drop && !(&w_cnt_base) ? w_cnt_base + OVF_CNT_W'(1) : w_cnt_base;
    end
  end
  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = w_out_valid;
  assign o_out_ch_valid = r_head[BW-1 -: NUM_CH] & {NUM_CH{w_out_valid}};
  assign o_out_data     = r_head[DW-1:0];
  assign o_used         = r_used;
  assign o_hwm          = r_hwm;
  assign o_ovf_sticky   = r_ovf_sticky;
  assign o_ovf_cnt      = r_ovf_cnt;
endmodule

// File: tb/tb_pcie_rx_avst_ingress_buf.sv
// tb_pcie_rx_avst_ingress_buf: randomized checks of the ingress buffer against a queue-based reference model
module tb_pcie_rx_avst_ingress_buf;
  localparam int DEPTH = 256;
  localparam int RL = 20;
  localparam int DW = 560;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          sclr, in_ready, out_valid, out_rdack, err_clr, ovf_sticky;
  logic [1:0]    in_valid, out_ch_valid;
  logic [DW-1:0] in_data, out_data;
  logic [8:0]    used, hwm;
  logic [15:0]   ovf_cnt;
  logic          s_sclr, s_valid, s_in_ready, s_out_valid, s_ch_valid, s_rdack, s_clr, s_sticky;
  logic [7:0]    s_data, s_out_data;
  logic [3:0]    s_used, s_hwm, s_cnt;
  pcie_rx_avst_ingress_buf dut (
    .i_clk(clk), .i_sclr(sclr), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_out_valid(out_valid), .o_out_ch_valid(out_ch_valid),
    .o_out_data(out_data), .i_out_rdack(out_rdack), .o_used(used), .o_hwm(hwm),
    .i_err_clr(err_clr), .o_ovf_sticky(ovf_sticky), .o_ovf_cnt(ovf_cnt)
  );
  pcie_rx_avst_ingress_buf #(.NUM_CH(1), .CH_DATA_W(8), .DEPTH_LOG2(3), .READY_LATENCY(2), .OVF_CNT_W(4)) dut_s (
    .i_clk(clk), .i_sclr(s_sclr), .i_in_valid(s_valid), .i_in_data(s_data),
    .o_in_ready(s_in_ready), .o_out_valid(s_out_valid), .o_out_ch_valid(s_ch_valid),
    .o_out_data(s_out_data), .i_out_rdack(s_rdack), .o_used(s_used), .o_hwm(s_hwm),
    .i_err_clr(s_clr), .o_ovf_sticky(s_sticky), .o_ovf_cnt(s_cnt)
  );
  int errs = 0;
  int checks = 0;
  logic [DW+1:0] mq[$];
  int m_hwm, m_cnt;
  bit m_st, m_rdy;
  function automatic logic [DW-1:0] rdat();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 18; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction
  // Drive one cycle on the main DUT and advance the reference model by the FIFO rules.
  task automatic cyc(input logic [1:0] v, input logic [DW-1:0] d, input logic rd, input logic clr, input logic rst);
    in_valid = v; in_data = d; out_rdack = rd; err_clr = clr; sclr = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_hwm = 0; m_cnt = 0; m_st = 0; m_rdy = 0;
    end else begin
      if (clr) begin m_hwm = 0; m_cnt = 0; m_st = 0; end
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (v != 2'b00) begin
        if (mq.size() < DEPTH) mq.push_back({v, d});
        else begin m_st = 1; if (m_cnt < 65535) m_cnt++; end
      end
      if (mq.size() > m_hwm) m_hwm = mq.size();
      m_rdy = mq.size() < DEPTH-RL;
    end
    #1;
  endtask
  task automatic cyc2(input logic v, input logic [7:0] d, input logic rd, input logic clr, input logic rst);
    s_valid = v; s_data = d; s_rdack = rd; s_clr = clr; s_sclr = rst;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(2'b00, '0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(2'b11, rdat(), 1'b0, 1'b0, 1'b0);
    checks++; if (used !== 9'd10) begin errs++; $display("FAIL pre_reset_used: got %0d want 10", used); end
    for (int i = 0; i < 3; i++) cyc(2'b11, rdat(), 1'b1, 1'b0, 1'b1);
    checks++; if (used !== 9'd0) begin errs++; $display("FAIL rst_used: got %0d want 0", used); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_ch_valid !== 2'b00) begin errs++; $display("FAIL rst_ch_valid: got %b want 00", out_ch_valid); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (hwm !== 9'd0) begin errs++; $display("FAIL rst_hwm: got %0d want 0", hwm); end
    checks++; if (ovf_sticky !== 1'b0 || ovf_cnt !== 16'd0) begin errs++; $display("FAIL rst_ovf: got %b/%0d want 0/0", ovf_sticky, ovf_cnt); end
    cyc(2'b00, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_ready();
    for (int i = 1; i <= 236; i++) begin
      cyc(2'b01, rdat(), 1'b0, 1'b0, 1'b0);
      if (i == 235) begin
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ready_at_235: got %b want 1", in_ready); end
      end
    end
    checks++; if (in_ready !== 1'b0 || used !== 9'd236) begin errs++; $display("FAIL ready_at_236: got rdy=%b used=%0d want 0/236", in_ready, used); end
    for (int i = 0; i < RL; i++) cyc(2'b01, rdat(), 1'b0, 1'b0, 1'b0);
    checks++; if (used !== 9'd256) begin errs++; $display("FAIL fill_used: got %0d want 256", used); end
    checks++; if (ovf_cnt !== 16'd0 || ovf_sticky !== 1'b0) begin errs++; $display("FAIL fill_no_drop: got %0d/%b want 0/0", ovf_cnt, ovf_sticky); end
    checks++; if (out_data !== mq[0][DW-1:0]) begin errs++; $display("FAIL fill_head: got %h want %h", out_data[31:0], mq[0][31:0]); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 5; i++) cyc(2'b11, rdat(), 1'b0, 1'b0, 1'b0);
    checks++; if (ovf_sticky !== 1'b1 || ovf_cnt !== 16'd5) begin errs++; $display("FAIL ovf_drop: got %b/%0d want 1/5", ovf_sticky, ovf_cnt); end
    checks++; if (used !== 9'd256) begin errs++; $display("FAIL ovf_used: got %0d want 256", used); end
    for (int i = 0; i < 5; i++) begin
      cyc(2'b10, rdat(), 1'b1, 1'b0, 1'b0);
      checks++; if (out_data !== mq[0][DW-1:0]) begin errs++; $display("FAIL full_pop_head: got %h want %h", out_data[31:0], mq[0][31:0]); end
    end
    checks++; if (ovf_cnt !== 16'd5 || used !== 9'd256) begin errs++; $display("FAIL full_pop: got cnt=%0d used=%0d want 5/256", ovf_cnt, used); end
    cyc(2'b00, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (ovf_sticky !== 1'b0 || ovf_cnt !== 16'd0 || hwm !== 9'd256) begin errs++; $display("FAIL err_clr: got %b/%0d/%0d want 0/0/256", ovf_sticky, ovf_cnt, hwm); end
  endtask
  task automatic test_sat();
    cyc2(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc2(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc2(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
    checks++; if (s_used !== 4'd8 || s_cnt !== 4'd0) begin errs++; $display("FAIL sat_fill: got used=%0d cnt=%0d want 8/0", s_used, s_cnt); end
    for (int i = 0; i < 20; i++) cyc2(1'b1, 8'hee, 1'b0, 1'b0, 1'b0);
    checks++; if (s_cnt !== 4'd15 || s_sticky !== 1'b1) begin errs++; $display("FAIL sat_cnt: got %0d/%b want 15/1", s_cnt, s_sticky); end
    checks++; if (s_out_data !== 8'h40 || s_used !== 4'd8) begin errs++; $display("FAIL sat_head: got %h used=%0d want 40/8", s_out_data, s_used); end
    cyc2(1'b1, 8'hee, 1'b0, 1'b1, 1'b0);
    checks++; if (s_cnt !== 4'd1 || s_sticky !== 1'b1 || s_hwm !== 4'd8) begin errs++; $display("FAIL clr_drop: got %0d/%b/%0d want 1/1/8", s_cnt, s_sticky, s_hwm); end
    cyc2(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++; if (s_cnt !== 4'd0 || s_sticky !== 1'b0 || s_hwm !== 4'd7) begin errs++; $display("FAIL clr_pop: got %0d/%b/%0d want 0/0/7", s_cnt, s_sticky, s_hwm); end
  endtask
  task automatic test_ch_valid();
    logic [DW-1:0] x, y;
    x = rdat(); y = rdat();
    cyc(2'b00, '0, 1'b0, 1'b0, 1'b1);
    cyc(2'b10, x, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_ch_valid !== 2'b10 || out_data !== x) begin errs++; $display("FAIL ch_first: got v=%b ch=%b want 1/10", out_valid, out_ch_valid); end
    cyc(2'b00, rdat(), 1'b0, 1'b0, 1'b0);
    cyc(2'b01, y, 1'b0, 1'b0, 1'b0);
    checks++; if (used !== 9'd2 || out_data !== x) begin errs++; $display("FAIL ch_hold: got used=%0d want 2", used); end
    cyc(2'b00, rdat(), 1'b1, 1'b0, 1'b0);
    checks++; if (out_ch_valid !== 2'b01 || out_data !== y || used !== 9'd1) begin errs++; $display("FAIL ch_second: got ch=%b used=%0d want 01/1", out_ch_valid, used); end
    cyc(2'b00, rdat(), 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_ch_valid !== 2'b00 || used !== 9'd0) begin errs++; $display("FAIL ch_empty: got v=%b ch=%b used=%0d want 0/00/0", out_valid, out_ch_valid, used); end
  endtask
  task automatic test_back_to_back();
    int sent = 0;
    int cyc_n = 0;
    logic [1:0] v;
    cyc(2'b00, '0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, '0, 1'b0, 1'b0, 1'b0);
    while ((sent < 600 || mq.size() > 0) && cyc_n < 5000) begin
      v = (sent < 600 && in_ready && $urandom_range(0, 3) != 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cyc(v, v != 2'b00 ? DW'(sent) : rdat(), sent >= 600 ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (v != 2'b00) sent++;
      cyc_n++;
      checks++; if (used !== 9'(mq.size()) || out_valid !== (mq.size() > 0)) begin errs++; $display("FAIL wrap_used: got %0d/%b want %0d", used, out_valid, mq.size()); end
      if (mq.size() > 0) begin
        checks++; if ({out_ch_valid, out_data} !== mq[0]) begin errs++; $display("FAIL wrap_head: got %b/%0d want %b/%0d", out_ch_valid, out_data[31:0], mq[0][DW+1:DW], mq[0][31:0]); end
      end
    end
    checks++; if (cyc_n >= 5000) begin errs++; $display("FAIL wrap_timeout: got %0d cycles want <5000", cyc_n); end
    checks++; if (hwm !== 9'(m_hwm)) begin errs++; $display("FAIL wrap_hwm: got %0d want %0d", hwm, m_hwm); end
    checks++; if (ovf_cnt !== 16'd0) begin errs++; $display("FAIL wrap_no_drop: got %0d want 0", ovf_cnt); end
  endtask
  initial begin
    s_sclr = 1'b1; s_valid = 1'b0; s_data = '0; s_rdack = 1'b0; s_clr = 1'b0;
    test_reset();
    test_ready();
    test_overflow();
    test_sat();
    test_ch_valid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
